matrix_output_mode: RTL

- Display-side counterpart of the UART matrix input mode.
- On command, it looks up a stored matrix slot in the matrix manager and reads its elements from BRAM in row-major order.
- It streams the matrix out over the UART transmitter as ASCII text: a dimension header line, then one line per row with space-separated decimal values.
- It sits beside the input mode under the top-level mode mux and shares the BRAM read port and the UART TX interface.

---
 rtl/matrix_output_mode_if.sv | 29 ++
 rtl/matrix_output_mode.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_output_mode_if.sv
// Bundles the matrix-manager query, BRAM read port and UART TX byte port.
// Latency: wires only. Query response is one cycle late and BRAM data is one cycle after mem_rd_en.
// Backpressure: tx_busy from the UART stalls new tx_start pulses.
interface matrix_output_mode_if #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10
);
  logic [3:0]               query_slot;
  logic                     query_valid;
  logic [3:0]               query_m;
  logic [3:0]               query_n;
  logic [ADDR_WIDTH-1:0]    query_addr;
  logic                     mem_rd_en;
  logic [ADDR_WIDTH-1:0]    mem_rd_addr;
  logic [ELEMENT_WIDTH-1:0] mem_rd_data;
  logic [7:0]               tx_data;
  logic                     tx_start;
  logic                     tx_busy;

  modport master (
    output query_slot, mem_rd_en, mem_rd_addr, tx_data, tx_start,
    input  query_valid, query_m, query_n, query_addr, mem_rd_data, tx_busy
  );

  modport slave (
    input  query_slot, mem_rd_en, mem_rd_addr, tx_data, tx_start,
    output query_valid, query_m, query_n, query_addr, mem_rd_data, tx_busy
  );
endinterface

// File: rtl/matrix_output_mode.sv
// Streams a stored matrix as ASCII text: "m n\r\n", then one line per row of decimal values.
// Latency: start -> first tx_start in 4 cycles; one BRAM read per element, issued only once the text queue is empty.
// Backpressure: each byte waits for tx_busy low, with one guard cycle after tx_start so the UART can raise busy.
module matrix_output_mode #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_active,
  input  logic                 start,
  input  logic [3:0]           slot_sel,
  matrix_output_mode_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           error_code,
  output logic [3:0]           sub_state
);

  localparam logic [3:0] ERR_NONE       = 4'd0;
  localparam logic [3:0] ERR_SLOT_EMPTY = 4'd5;

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_E  = 8'h45;

  typedef enum logic [3:0] {
    IDLE = 4'd0, QUERY = 4'd1, CHECK = 4'd2, SEND = 4'd3, TX_WAIT = 4'd4,
    RD_REQ = 4'd5, RD_WAIT = 4'd6, FORMAT = 4'd7, DONE = 4'd8, ERROR = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            query_slot_q, query_slot_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [3:0]            err_q, err_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]            m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, idx_q, idx_d;
  logic                  fin_q, fin_d;
  logic [7:0]            val_q, val_d;
  // Eight entries: a header with two 2-digit dimensions plus CR LF is 7 bytes.
  logic [7:0][7:0]       chq_q, chq_d;
  logic [2:0]            ptr_q, ptr_d, len_q, len_d;

  logic [ELEMENT_WIDTH-1:0] rd_word;
  logic [2:0]               w_c;
  logic [3:0]               hund_c, tens_c;
  logic [7:0]               lo_c;

  assign rd_word = bus.mem_rd_data;

  function automatic logic [7:0] dig(input logic [3:0] d);
    return CH_0 + {4'h0, d};
  endfunction

  // Next-state logic: sequencing, text-queue loading and decimal conversion.
  always_comb begin
    state_d      = state_q;
    query_slot_d = query_slot_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    m_d = m_q; n_d = n_q; row_d = row_q; col_d = col_q;
    base_d = base_q; idx_d = idx_q; fin_d = fin_q; val_d = val_q;
    chq_d = chq_q; ptr_d = ptr_q; len_d = len_q;
    w_c = 3'd0; hund_c = 4'd0; tens_c = 4'd0; lo_c = 8'd0;

    if (!mode_active) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      err_d   = ERR_NONE;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (start) begin
            query_slot_d = slot_sel;
            busy_d       = 1'b1;
            err_d        = ERR_NONE;
            state_d      = QUERY;
          end
        end
        QUERY: state_d = CHECK;
        CHECK: begin
          if (!bus.query_valid || bus.query_m == 4'd0 || bus.query_n == 4'd0) begin
            // The "E" marker still respects a busy UART.
            if (!bus.tx_busy) begin
              err_d      = ERR_SLOT_EMPTY;
              tx_data_d  = CH_E;
              tx_start_d = 1'b1;
              busy_d     = 1'b0;
              state_d    = ERROR;
            end
          end else begin
            m_d = bus.query_m; n_d = bus.query_n; base_d = bus.query_addr;
            row_d = 4'd0; col_d = 4'd0; idx_d = '0; fin_d = 1'b0;
            if (bus.query_m >= 4'd10) begin
              chq_d[w_c] = dig(4'd1); w_c = w_c + 3'd1;
              chq_d[w_c] = dig(bus.query_m - 4'd10);
            end else begin
              chq_d[w_c] = dig(bus.query_m);
            end
            w_c = w_c + 3'd1;
            chq_d[w_c] = CH_SP; w_c = w_c + 3'd1;
            if (bus.query_n >= 4'd10) begin
              chq_d[w_c] = dig(4'd1); w_c = w_c + 3'd1;
              chq_d[w_c] = dig(bus.query_n - 4'd10);
            end else begin
              chq_d[w_c] = dig(bus.query_n);
            end
            w_c = w_c + 3'd1;
            chq_d[w_c] = CH_CR; w_c = w_c + 3'd1;
            chq_d[w_c] = CH_LF; w_c = w_c + 3'd1;
            ptr_d   = 3'd0;
            len_d   = w_c;
            state_d = SEND;
          end
        end
        SEND: begin
          if (ptr_q == len_q) begin
            if (fin_q) begin
              state_d = DONE;
            end else begin
              // Strobe is registered, so it is high during RD_REQ.
              rd_en_d   = 1'b1;
              rd_addr_d = base_q + idx_q;
              state_d   = RD_REQ;
            end
          end else if (!bus.tx_busy) begin
            tx_data_d  = chq_q[ptr_q];
            tx_start_d = 1'b1;
            ptr_d      = ptr_q + 3'd1;
            state_d    = TX_WAIT;
          end
        end
        // tx_start_q is high only in the first TX_WAIT cycle: that is the guard cycle.
        TX_WAIT: if (!tx_start_q && !bus.tx_busy) state_d = SEND;
        RD_REQ:  state_d = RD_WAIT;
        RD_WAIT: begin
          val_d   = rd_word[7:0];
          state_d = FORMAT;
        end
        FORMAT: begin
          lo_c = val_q;
          if (val_q >= 8'd200) begin
            hund_c = 4'd2; lo_c = val_q - 8'd200;
          end else if (val_q >= 8'd100) begin
            hund_c = 4'd1; lo_c = val_q - 8'd100;
          end
          for (int k = 0; k < 9; k++) begin
            if (lo_c >= 8'd10) begin
              lo_c   = lo_c - 8'd10;
              tens_c = tens_c + 4'd1;
            end
          end
          if (hund_c != 4'd0) begin
            chq_d[w_c] = dig(hund_c); w_c = w_c + 3'd1;
          end
          if (hund_c != 4'd0 || tens_c != 4'd0) begin
            chq_d[w_c] = dig(tens_c); w_c = w_c + 3'd1;
          end
          chq_d[w_c] = dig(lo_c[3:0]); w_c = w_c + 3'd1;
          if (col_q != n_q - 4'd1) begin
            chq_d[w_c] = CH_SP; w_c = w_c + 3'd1;
            col_d = col_q + 4'd1;
          end else begin
            chq_d[w_c] = CH_CR; w_c = w_c + 3'd1;
            chq_d[w_c] = CH_LF; w_c = w_c + 3'd1;
            col_d = 4'd0;
            row_d = row_q + 4'd1;
            if (row_q == m_q - 4'd1) fin_d = 1'b1;
          end
          idx_d   = idx_q + 1'b1;
          ptr_d   = 3'd0;
          len_d   = w_c;
          state_d = SEND;
        end
        DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; query_slot_q <= 4'd0; busy_q <= 1'b0; done_q <= 1'b0;
      err_q <= ERR_NONE; tx_data_q <= 8'd0; tx_start_q <= 1'b0;
      rd_en_q <= 1'b0; rd_addr_q <= '0;
      m_q <= 4'd0; n_q <= 4'd0; row_q <= 4'd0; col_q <= 4'd0;
      base_q <= '0; idx_q <= '0; fin_q <= 1'b0; val_q <= 8'd0;
      chq_q <= '0; ptr_q <= 3'd0; len_q <= 3'd0;
    end else begin
      state_q <= state_d; query_slot_q <= query_slot_d; busy_q <= busy_d; done_q <= done_d;
      err_q <= err_d; tx_data_q <= tx_data_d; tx_start_q <= tx_start_d;
      rd_en_q <= rd_en_d; rd_addr_q <= rd_addr_d;
      m_q <= m_d; n_q <= n_d; row_q <= row_d; col_q <= col_d;
      base_q <= base_d; idx_q <= idx_d; fin_q <= fin_d; val_q <= val_d;
      chq_q <= chq_d; ptr_q <= ptr_d; len_q <= len_d;
    end
  end

  assign bus.query_slot  = query_slot_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error_code      = err_q;
  assign sub_state       = state_q;

endmodule
